// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one data-memory transaction per request.
// Byte lanes, load extension, misalignment/illegal checks and bus timeout.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             misaligned,
  output logic             illegal,
  output logic             bus_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    FINISH
  } state_t;

  state_t         state;
  logic           st_q;
  logic [2:0]     f3_q;
  logic [1:0]     lo_q;
  logic [CW-1:0]  cnt;

  logic             req_ill;
  logic             req_mis;
  logic [3:0]       req_be;
  logic [WIDTH-1:0] req_wd;
  logic [WIDTH-1:0] shf;
  logic [WIDTH-1:0] ext;

  always_comb begin
    req_mis = 1'b0;
    req_be  = 4'b1111;
    req_wd  = wdata;
    if (is_store)
      req_ill = !(funct3 inside {3'b000, 3'b001, 3'b010});
    else
      req_ill = funct3 inside {3'b011, 3'b110, 3'b111};
    case (funct3[1:0])
      2'b00: begin
        req_be = 4'b0001 << addr[1:0];
        req_wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_be  = 4'b0011 << {addr[1], 1'b0};
        req_wd  = {2{wdata[15:0]}};
        req_mis = addr[0];
      end
      default: begin
        req_mis = addr[1:0] != 2'b00;
      end
    endcase
    req_mis = req_mis & !req_ill;
  end

  // Lane select is a right shift by the byte offset of the access.
  always_comb begin
    shf = mem_rdata >> {lo_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{shf[7]}}, shf[7:0]};
      3'b100:  ext = {24'b0, shf[7:0]};
      3'b001:  ext = {{16{shf[15]}}, shf[15:0]};
      3'b101:  ext = {16'b0, shf[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      st_q       <= 1'b0;
      f3_q       <= '0;
      lo_q       <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            st_q <= is_store;
            f3_q <= funct3;
            lo_q <= addr[1:0];
            busy <= 1'b1;
            cnt  <= '0;
            if (req_ill || req_mis) begin
              illegal    <= req_ill;
              misaligned <= req_mis;
              done       <= 1'b1;
              state      <= FINISH;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[WIDTH-1:2], 2'b00};
              mem_be    <= req_be;
              mem_wdata <= req_wd;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          // mem_ready wins over a timeout on the same cycle.
          if (mem_ready || cnt == LAST) begin
            if (mem_ready && !st_q)
              rdata <= ext;
            bus_err <= !mem_ready;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            done    <= 1'b1;
            state   <= FINISH;
          end
        end
        FINISH: begin
          busy       <= 1'b0;
          misaligned <= 1'b0;
          illegal    <= 1'b0;
          bus_err    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Responds on the memory bus after a programmable number of request cycles.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        illegal;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  int          lat;
  int          req_cycles;
  logic        got_done;
  logic        s_busy;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [31:0] s_wd;
  logic        s_mis;
  logic        s_ill;
  logic        s_err;
  logic [31:0] s_rd;

  load_store_unit #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .is_store(is_store),
    .funct3(funct3),
    .addr(addr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .rdata(rdata),
    .misaligned(misaligned),
    .illegal(illegal),
    .bus_err(bus_err),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // wait_n: request cycles before ready; -1 means never.
  task automatic run_op(input logic        st,
                        input logic [2:0]  f3,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] rw,
                        input int          wait_n);
    @(negedge clk);
    start = 1'b1;
    is_store = st;
    funct3 = f3;
    addr = a;
    wdata = wd;
    mem_rdata = rw;
    mem_ready = 1'b0;
    lat = 0;
    req_cycles = 0;
    got_done = 1'b0;
    s_busy = 1'b0;
    s_we = 1'b0;
    s_be = 4'b0;
    s_addr = '0;
    s_wd = '0;
    while (!got_done && lat < 100) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 1) s_busy = busy;
      if (mem_req) begin
        req_cycles++;
        s_we = mem_we;
        s_be = mem_be;
        s_addr = mem_addr;
        s_wd = mem_wdata;
        mem_ready = (wait_n >= 0) && (req_cycles > wait_n);
      end else begin
        mem_ready = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        s_mis = misaligned;
        s_ill = illegal;
        s_err = bus_err;
        s_rd = rdata;
      end
    end
    mem_ready = 1'b0;
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    is_store = 1'b0;
    funct3 = 3'b000;
    addr = '0;
    wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_be", {28'b0, mem_be}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    reset = 1'b1;

    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_lat", lat, 2);
    check("lw_busy", {31'b0, s_busy}, 32'd1);
    check("lw_be", {28'b0, s_be}, 32'hF);
    check("lw_addr", s_addr, 32'h100);
    check("lw_we", {31'b0, s_we}, 32'd0);
    check("lw_rdata", s_rd, 32'hDEADBEEF);
    check("lw_flags", {29'b0, s_mis, s_ill, s_err}, 32'd0);

    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 0);
    check("lb_be", {28'b0, s_be}, 32'h8);
    check("lb_rdata", s_rd, 32'hFFFFFF80);

    run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 0);
    check("lbu_rdata", s_rd, 32'h00000080);

    run_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0);
    check("sh_we", {31'b0, s_we}, 32'd1);
    check("sh_be", {28'b0, s_be}, 32'hC);
    check("sh_wdata", s_wd, 32'hABCDABCD);
    check("sh_addr", s_addr, 32'h200);
    check("sh_rd_hold", s_rd, 32'h00000080);

    run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    check("mis_lat", lat, 1);
    check("mis_req", req_cycles, 0);
    check("mis_flag", {31'b0, s_mis}, 32'd1);
    check("mis_ill", {31'b0, s_ill}, 32'd0);

    run_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    check("ill_lat", lat, 1);
    check("ill_flag", {31'b0, s_ill}, 32'd1);
    check("ill_req", req_cycles, 0);

    run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 2);
    check("lh_lat", lat, 4);
    check("lh_be", {28'b0, s_be}, 32'hC);
    check("lh_rdata", s_rd, 32'hFFFF8001);

    run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0);
    check("lhu_rdata", s_rd, 32'h00008001);

    run_op(1'b1, 3'b000, 32'h101, 32'h0000005A, 32'h0, 0);
    check("sb_be", {28'b0, s_be}, 32'h2);
    check("sb_wdata", s_wd, 32'h5A5A5A5A);

    run_op(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    check("sill_flag", {31'b0, s_ill}, 32'd1);
    check("sill_req", req_cycles, 0);

    run_op(1'b0, 3'b010, 32'h400, 32'h0, 32'h11111111, -1);
    check("to_req", req_cycles, 16);
    check("to_lat", lat, 17);
    check("to_err", {31'b0, s_err}, 32'd1);
    check("to_rd_hold", s_rd, 32'h00008001);

    run_op(1'b0, 3'b010, 32'h404, 32'h0, 32'h22222222, 15);
    check("late_req", req_cycles, 16);
    check("late_err", {31'b0, s_err}, 32'd0);
    check("late_rdata", s_rd, 32'h22222222);

    @(negedge clk);
    start = 1'b1;
    is_store = 1'b0;
    funct3 = 3'b010;
    addr = 32'h500;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ra_req_pre", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ra_req", {31'b0, mem_req}, 32'd0);
    check("ra_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 0);
    check("post_lat", lat, 2);
    check("post_rdata", s_rd, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
